vigna_bus_arbiter: RTL and testbench
====================================

VIGNA_BUS_ARBITER -- requirements
Module: vigna_bus_arbiter

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 0: cycles waiting for m_ready before forced error completion; 0 disables the watchdog.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have i_valid  input  1,  i_ready  output  1,  i_addr  input  32,  i_rdata  output  32; instruction requester, read-only.
REQ-005 SHALL have d_valid  input  1,  d_ready  output  1,  d_addr  input  32,  d_rdata  output  32,  d_wdata  input  32,  d_wstrb  input  4; data requester; d_wstrb==0 means read.
REQ-006 SHALL have m_valid  output  1,  m_ready  input  1,  m_addr  output  32,  m_rdata  input  32,  m_wdata  output  32,  m_wstrb  output  4; shared memory port.
REQ-007 SHALL have bus_err  output  1; one-cycle pulse on watchdog completion.

Function
REQ-008 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, TURN.
REQ-009 In IDLE, with i_valid or d_valid high, SHALL move to BUSY_I or BUSY_D per REQ-014/REQ-015, latching the winner's addr/wdata/wstrb into m_addr/m_wdata/m_wstrb and setting m_valid=1 on that edge.
REQ-010 For an I grant, m_wstrb SHALL be 4'b0000 and m_wdata SHALL be 0.
REQ-011 In BUSY_x, m_valid and latched outputs SHALL hold stable until m_ready=1; x_ready SHALL equal m_ready combinationally, and x_rdata SHALL equal m_rdata; the non-granted ready SHALL be 0.
REQ-012 On the m_ready=1 edge in BUSY_x: m_valid<=0, m_wstrb<=0, state<=TURN.
REQ-013 TURN SHALL last exactly one cycle with no grant, so a requester dropping valid after its ready is never re-issued; TURN->IDLE.
REQ-014 When exactly one valid is high in IDLE, that requester SHALL be granted.
REQ-015 When both are high in IDLE, tie SHALL be resolved per Configuration (REQ-021/022).
REQ-016 Minimum latency: valid seen in IDLE at cycle N -> m_valid at N+1 -> ready earliest at N+1 (m_ready same cycle) -> next grant at N+3.
REQ-017 With TIMEOUT>0, a counter SHALL clear on each grant and increment each BUSY cycle with m_ready=0; on reaching TIMEOUT, x_ready SHALL pulse 1 with x_rdata=0, bus_err SHALL pulse 1, m_valid<=0, state<=TURN.
REQ-018 m_ready arriving in the same cycle as the watchdog limit SHALL be treated as normal completion, with bus_err=0.
REQ-019 m_ready while in IDLE or TURN SHALL be ignored.
REQ-020 A requester dropping valid before ready SHALL NOT cancel an in-flight memory transaction.

Configuration
REQ-021 With macro VIGNA_ARB_ROUND_ROBIN_EN defined, ties SHALL go to the requester not granted last; the last-grant register SHALL update on each grant and reset to D, so the first tie goes to I.
REQ-022 Without the macro, ties SHALL always go to D (fixed data priority), and no last-grant register SHALL exist.

Reset
REQ-023 On reset: state=IDLE, m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, bus_err=0, watchdog counter=0, last-grant=D.
REQ-024 i_ready and d_ready SHALL be 0 in the cycle after the reset edge.
REQ-025 Reset asserted mid-transaction SHALL abandon it, dropping m_valid at that edge with no ready pulse to the requester.

Structure
REQ-026 SHALL use shared package vigna_bus_pkg holding the FSM state encoding, grant constants GNT_I/GNT_D, and the width constant 32.
REQ-027 Tie/priority selection SHALL be a combinational sub-module vigna_arb_pick (inputs i_valid, d_valid, last_grant; output grant).

Verification
REQ-028 Lone I read: i_valid, i_addr=0x100; m_ready=1 two cycles after grant with m_rdata=0xDEADBEEF -> m_addr=0x100, m_wstrb=0, i_ready pulse, i_rdata=0xDEADBEEF, d_ready=0.
REQ-029 Lone D store: d_addr=0x2004, d_wdata=0x55AA, d_wstrb=4'b0011 -> m_* carries identical values; d_ready pulses with m_ready; m_wstrb is 0 after.
REQ-030 Simultaneous valids, both held across three rounds -> RR build grants I,D,I; fixed build grants D,D,D; the TURN gap is observed each time.
REQ-031 TIMEOUT=8, m_ready tied 0 -> after 8 busy cycles i_ready=1, i_rdata=0, bus_err=1 for one cycle, m_valid=0; m_ready in cycle 8 -> no bus_err.
REQ-032 Reset pulse in BUSY_D cycle 2 -> m_valid=0 next cycle, no d_ready; a subsequent D request completes normally.

Source files
------------

// File: rtl/vigna_bus_pkg.sv
// Shared types and constants for the Vigna instruction/data bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vigna_bus_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        TURN   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;

endpackage

// File: rtl/vigna_bus_arbiter_if.sv
// Bundle of the instruction, data and shared memory port signals of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on each side; the arbiter drives i_ready/d_ready from m_ready.
// Modports: slave = arbiter view, master = requester + memory view.
interface vigna_bus_arbiter_if;
    import vigna_bus_pkg::*;

    // instruction requester (read-only)
    logic            i_valid;
    logic            i_ready;
    logic [XLEN-1:0] i_addr;
    logic [XLEN-1:0] i_rdata;
    // data requester (d_wstrb == 0 means read)
    logic            d_valid;
    logic            d_ready;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_rdata;
    logic [XLEN-1:0] d_wdata;
    logic [3:0]      d_wstrb;
    // shared memory port
    logic            m_valid;
    logic            m_ready;
    logic [XLEN-1:0] m_addr;
    logic [XLEN-1:0] m_rdata;
    logic [XLEN-1:0] m_wdata;
    logic [3:0]      m_wstrb;
    // watchdog completion pulse
    logic            bus_err;

    modport slave (
        input  i_valid, i_addr,
        input  d_valid, d_addr, d_wdata, d_wstrb,
        input  m_ready, m_rdata,
        output i_ready, i_rdata,
        output d_ready, d_rdata,
        output m_valid, m_addr, m_wdata, m_wstrb,
        output bus_err
    );

    modport master (
        output i_valid, i_addr,
        output d_valid, d_addr, d_wdata, d_wstrb,
        output m_ready, m_rdata,
        input  i_ready, i_rdata,
        input  d_ready, d_rdata,
        input  m_valid, m_addr, m_wdata, m_wstrb,
        input  bus_err
    );

endinterface

// File: rtl/vigna_arb_pick.sv
// Grant selection between instruction and data requesters (combinational).
// Latency: 0 cycles. Backpressure: none; caller only uses grant when a valid is high.
// Ports: i_valid, d_valid, last_grant in; grant out. Macro VIGNA_ARB_ROUND_ROBIN_EN
// selects round-robin ties; otherwise ties always go to D.
module vigna_arb_pick
    import vigna_bus_pkg::*;
(
    input  logic i_valid,
    input  logic d_valid,
    input  gnt_t last_grant,
    output gnt_t grant
);

    always_comb begin
        grant = GNT_D;
        if (i_valid && !d_valid) begin
            grant = GNT_I;
        end else if (i_valid && d_valid) begin
`ifdef VIGNA_ARB_ROUND_ROBIN_EN
            // alternate: the requester not served last wins the tie
            grant = (last_grant == GNT_D) ? GNT_I : GNT_D;
`else
            grant = GNT_D;
`endif
        end
    end

`ifndef VIGNA_ARB_ROUND_ROBIN_EN
    // fixed priority ignores history
    logic unused_last_grant;
    assign unused_last_grant = (last_grant == GNT_I);
`endif

endmodule

// File: rtl/vigna_bus_arbiter.sv
// Arbitrates an instruction and a data requester onto one memory port, with optional watchdog.
// Latency: grant registered 1 cycle after valid in IDLE; ready follows m_ready combinationally; one TURN cycle per transfer.
// Backpressure: m_valid and latched request held until m_ready (or watchdog expiry at TIMEOUT>0).
// Ports: clk, reset (sync, active-high), bus (vigna_bus_arbiter_if.slave). Macro: VIGNA_ARB_ROUND_ROBIN_EN.
module vigna_bus_arbiter
    import vigna_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0
) (
    input logic                clk,
    input logic                reset,
    vigna_bus_arbiter_if.slave bus
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t      state_q;
    logic            m_valid_q;
    logic [XLEN-1:0] m_addr_q;
    logic [XLEN-1:0] m_wdata_q;
    logic [3:0]      m_wstrb_q;
    logic [CW-1:0]   wd_cnt_q;
    logic [CW-1:0]   wd_lim;
    gnt_t            last_gnt;
    gnt_t            pick_gnt;
    logic            busy;
    logic            busy_i;
    logic            busy_d;
    logic            wd_hit;

`ifdef VIGNA_ARB_ROUND_ROBIN_EN
    gnt_t last_gnt_q;
    assign last_gnt = last_gnt_q;
`else
    assign last_gnt = GNT_D;
`endif

    vigna_arb_pick u_pick (
        .i_valid    (bus.i_valid),
        .d_valid    (bus.d_valid),
        .last_grant (last_gnt),
        .grant      (pick_gnt)
    );

    assign wd_lim = CW'(TIMEOUT - 1);
    // ready and the watchdog are blanked while reset is asserted so an abandoned
    // transfer never completes toward the requester
    assign busy_i = (state_q == BUSY_I) && !reset;
    assign busy_d = (state_q == BUSY_D) && !reset;
    assign busy   = busy_i || busy_d;
    // m_ready in the limit cycle wins: that is a normal completion
    assign wd_hit = (TIMEOUT != 0) && busy && !bus.m_ready && (wd_cnt_q == wd_lim);

    assign bus.i_ready = busy_i && (bus.m_ready || wd_hit);
    assign bus.d_ready = busy_d && (bus.m_ready || wd_hit);
    assign bus.i_rdata = (busy_i && !wd_hit) ? bus.m_rdata : '0;
    assign bus.d_rdata = (busy_d && !wd_hit) ? bus.m_rdata : '0;
    assign bus.bus_err = wd_hit;

    assign bus.m_valid = m_valid_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_wstrb = m_wstrb_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            m_valid_q  <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_wstrb_q  <= '0;
            wd_cnt_q   <= '0;
`ifdef VIGNA_ARB_ROUND_ROBIN_EN
            last_gnt_q <= GNT_D;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_valid || bus.d_valid) begin
                        m_valid_q <= 1'b1;
                        wd_cnt_q  <= '0;
`ifdef VIGNA_ARB_ROUND_ROBIN_EN
                        last_gnt_q <= pick_gnt;
`endif
                        if (pick_gnt == GNT_I) begin
                            state_q   <= BUSY_I;
                            m_addr_q  <= bus.i_addr;
                            m_wdata_q <= '0;
                            m_wstrb_q <= '0;
                        end else begin
                            state_q   <= BUSY_D;
                            m_addr_q  <= bus.d_addr;
                            m_wdata_q <= bus.d_wdata;
                            m_wstrb_q <= bus.d_wstrb;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.m_ready || wd_hit) begin
                        m_valid_q <= 1'b0;
                        m_wstrb_q <= '0;
                        state_q   <= TURN;
                    end else if (TIMEOUT != 0) begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                // dead cycle: a requester that just saw ready can drop valid
                TURN:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// Directed self-checking bench for vigna_bus_arbiter (TIMEOUT=8).
// Latency: n/a. Backpressure: memory ready driven by the bench.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_vigna_bus_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [2:0] tie_d;

    vigna_bus_arbiter_if bus ();

    vigna_bus_arbiter #(.TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
`ifdef VIGNA_ARB_ROUND_ROBIN_EN
        tie_d = 3'b010;   // rounds 0..2: I, D, I
`else
        tie_d = 3'b111;   // always D
`endif
        reset = 1'b1;
        bus.i_valid = 0; bus.i_addr = 0;
        bus.d_valid = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_wstrb = 0;
        bus.m_ready = 1; bus.m_rdata = 32'h1111_1111;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state; m_ready high in IDLE must be ignored
        mid();
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_addr",  bus.m_addr,       32'd0);
        chk("rst_m_wdata", bus.m_wdata,      32'd0);
        chk("rst_m_wstrb", 32'(bus.m_wstrb), 32'd0);
        chk("rst_bus_err", 32'(bus.bus_err), 32'd0);
        chk("rst_i_ready", 32'(bus.i_ready), 32'd0);
        chk("rst_d_ready", 32'(bus.d_ready), 32'd0);
        step();

        // lone instruction read, memory answers in the third busy cycle
        bus.m_ready = 0;
        bus.i_valid = 1; bus.i_addr = 32'h100;
        mid();
        chk("i_idle_m_valid", 32'(bus.m_valid), 32'd0);
        step();
        mid();
        chk("i_m_valid", 32'(bus.m_valid), 32'd1);
        chk("i_m_addr",  bus.m_addr,       32'h100);
        chk("i_m_wstrb", 32'(bus.m_wstrb), 32'd0);
        chk("i_m_wdata", bus.m_wdata,      32'd0);
        chk("i_wait_ready", 32'(bus.i_ready), 32'd0);
        step();
        step();
        bus.m_ready = 1; bus.m_rdata = 32'hDEAD_BEEF;
        mid();
        chk("i_ready",   32'(bus.i_ready), 32'd1);
        chk("i_rdata",   bus.i_rdata,      32'hDEAD_BEEF);
        chk("i_d_ready", 32'(bus.d_ready), 32'd0);
        chk("i_bus_err", 32'(bus.bus_err), 32'd0);
        step();
        bus.i_valid = 0; bus.m_ready = 0;
        mid();
        chk("i_turn_m_valid", 32'(bus.m_valid), 32'd0);
        chk("i_turn_i_ready", 32'(bus.i_ready), 32'd0);
        step();
        mid();
        chk("i_no_reissue", 32'(bus.m_valid), 32'd0);
        step();

        // lone data store; valid dropped before ready must not cancel it
        bus.d_valid = 1; bus.d_addr = 32'h2004; bus.d_wdata = 32'h55AA; bus.d_wstrb = 4'b0011;
        step();
        mid();
        chk("d_m_valid", 32'(bus.m_valid), 32'd1);
        chk("d_m_addr",  bus.m_addr,       32'h2004);
        chk("d_m_wdata", bus.m_wdata,      32'h55AA);
        chk("d_m_wstrb", 32'(bus.m_wstrb), 32'h3);
        chk("d_wait_ready", 32'(bus.d_ready), 32'd0);
        step();
        bus.d_valid = 0;
        mid();
        chk("d_drop_m_valid", 32'(bus.m_valid), 32'd1);
        chk("d_drop_m_addr",  bus.m_addr,       32'h2004);
        step();
        bus.m_ready = 1; bus.m_rdata = 32'h1234_5678;
        mid();
        chk("d_ready",   32'(bus.d_ready), 32'd1);
        chk("d_rdata",   bus.d_rdata,      32'h1234_5678);
        chk("d_i_ready", 32'(bus.i_ready), 32'd0);
        step();
        bus.m_ready = 0;
        mid();
        chk("d_after_m_valid", 32'(bus.m_valid), 32'd0);
        chk("d_after_m_wstrb", 32'(bus.m_wstrb), 32'd0);
        step();

        // both requesters held for three rounds, ready in the grant cycle
        bus.i_valid = 1; bus.i_addr = 32'h300;
        bus.d_valid = 1; bus.d_addr = 32'h400; bus.d_wdata = 32'hCAFE; bus.d_wstrb = 4'hF;
        for (int r = 0; r < 3; r++) begin
            mid();
            chk($sformatf("tie%0d_idle_m_valid", r), 32'(bus.m_valid), 32'd0);
            step();
            mid();
            chk($sformatf("tie%0d_m_addr", r),  bus.m_addr,
                tie_d[r] ? 32'h400 : 32'h300);
            chk($sformatf("tie%0d_m_wstrb", r), 32'(bus.m_wstrb),
                tie_d[r] ? 32'hF : 32'h0);
            bus.m_ready = 1; bus.m_rdata = 32'hA5A5_0000 + 32'(r);
            #1;
            chk($sformatf("tie%0d_i_ready", r), 32'(bus.i_ready), 32'(!tie_d[r]));
            chk($sformatf("tie%0d_d_ready", r), 32'(bus.d_ready), 32'(tie_d[r]));
            step();
            bus.m_ready = 0;
            mid();
            chk($sformatf("tie%0d_turn_m_valid", r), 32'(bus.m_valid), 32'd0);
            chk($sformatf("tie%0d_turn_readies", r),
                32'({bus.i_ready, bus.d_ready}), 32'd0);
            step();
        end
        bus.i_valid = 0; bus.d_valid = 0; bus.d_wstrb = 0; bus.d_wdata = 0;
        step();

        // watchdog expiry with m_ready stuck low
        bus.i_valid = 1; bus.i_addr = 32'h500; bus.m_rdata = 32'hFFFF_FFFF;
        step();
        for (int k = 1; k <= 8; k++) begin
            mid();
            chk($sformatf("wd_c%0d_m_valid", k), 32'(bus.m_valid), 32'd1);
            chk($sformatf("wd_c%0d_i_ready", k), 32'(bus.i_ready), (k == 8) ? 32'd1 : 32'd0);
            chk($sformatf("wd_c%0d_bus_err", k), 32'(bus.bus_err), (k == 8) ? 32'd1 : 32'd0);
            if (k == 8) chk("wd_i_rdata", bus.i_rdata, 32'd0);
            step();
        end
        bus.i_valid = 0;
        mid();
        chk("wd_after_m_valid", 32'(bus.m_valid), 32'd0);
        chk("wd_after_bus_err", 32'(bus.bus_err), 32'd0);
        chk("wd_after_i_ready", 32'(bus.i_ready), 32'd0);
        step();
        step();

        // m_ready in the limit cycle is a normal completion
        bus.i_valid = 1; bus.i_addr = 32'h504; bus.m_rdata = 32'h0BAD_F00D;
        step();
        repeat (7) step();
        bus.m_ready = 1;
        mid();
        chk("wdr_i_ready", 32'(bus.i_ready), 32'd1);
        chk("wdr_i_rdata", bus.i_rdata,      32'h0BAD_F00D);
        chk("wdr_bus_err", 32'(bus.bus_err), 32'd0);
        step();
        bus.i_valid = 0; bus.m_ready = 0;
        mid();
        chk("wdr_turn_m_valid", 32'(bus.m_valid), 32'd0);
        chk("wdr_turn_bus_err", 32'(bus.bus_err), 32'd0);
        step();
        step();

        // reset in the second BUSY_D cycle abandons the transfer
        bus.d_valid = 1; bus.d_addr = 32'h600; bus.d_wstrb = 0; bus.d_wdata = 0;
        step();
        step();
        reset = 1; bus.m_ready = 1;
        mid();
        chk("rstmid_d_ready", 32'(bus.d_ready), 32'd0);
        step();
        reset = 0; bus.m_ready = 0;
        mid();
        chk("rstmid_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rstmid_m_addr",  bus.m_addr,       32'd0);
        chk("rstmid_d_ready2", 32'(bus.d_ready), 32'd0);
        step();
        mid();
        chk("rstre_m_valid", 32'(bus.m_valid), 32'd1);
        chk("rstre_m_addr",  bus.m_addr,       32'h600);
        bus.m_ready = 1; bus.m_rdata = 32'h600D_600D;
        #1;
        chk("rstre_d_ready", 32'(bus.d_ready), 32'd1);
        chk("rstre_d_rdata", bus.d_rdata,      32'h600D_600D);
        step();
        bus.d_valid = 0; bus.m_ready = 0;
        mid();
        chk("rstre_turn_m_valid", 32'(bus.m_valid), 32'd0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
